// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the nibble-serial external memory bus between
// the instruction-fetch port and the load/store port, then sequences the
// address phase and the 2/4/8 nibble beats of the winning transaction.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        iReq,
    input  logic [23:0] iAddr,
    output logic        iDone,
    output logic [31:0] iData,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [1:0]  dType,
    input  logic [23:0] dAddr,
    input  logic [31:0] dWdata,
    output logic        dDone,
    output logic [31:0] dRdata,
    output logic        err,
    output logic        busy,
    output logic        memReq,
    input  logic        memAck,
    output logic        memWe,
    output logic [1:0]  memType,
    output logic [23:0] memAddr,
    output logic [3:0]  memNibOut,
    input  logic [3:0]  memNibIn,
    input  logic        memStb
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_XFER,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;      // 0 = fetch, 1 = data
    logic            we_q, we_d;
    logic [1:0]      type_q, type_d;
    logic [23:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rbuf_q, rbuf_d;
    logic [2:0]      beat_q, beat_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [31:0]     idata_q, idata_d;
    logic [31:0]     drdata_q, drdata_d;

    logic            fetch_win, data_win, req_err;
    logic [1:0]      g_type;
    logic [23:0]     g_addr;
    logic [2:0]      last_beat;
    logic [31:0]     rbuf_ins;
    logic            tmo_hit;

    // Arbitration and request validation for the IDLE cycle
    always_comb begin
        fetch_win = iReq && (!dReq || (streak_q == SW'(STARVE_LIMIT)));
        data_win  = dReq && !fetch_win;
        g_type    = fetch_win ? 2'b11 : dType;
        g_addr    = fetch_win ? iAddr : dAddr;
        req_err   = (g_type == 2'b00) ||
                    ((g_type == 2'b10) && g_addr[0]) ||
                    ((g_type == 2'b11) && (g_addr[1:0] != 2'b00));
    end

    // Beat count, read-buffer nibble insertion and timeout detect
    always_comb begin
        case (type_q)
            2'b01:   last_beat = 3'd1;
            2'b10:   last_beat = 3'd3;
            default: last_beat = 3'd7;
        endcase
        rbuf_ins = rbuf_q;
        rbuf_ins[{beat_q, 2'b00} +: 4] = memNibIn;
        tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 1));
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        type_d   = type_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        beat_d   = beat_q;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        idata_d  = idata_q;
        drdata_d = drdata_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_win || data_win) begin
                    owner_d = data_win;
                    we_d    = data_win && dWe;
                    type_d  = g_type;
                    addr_d  = g_addr;
                    wdata_d = data_win ? dWdata : '0;
                    rbuf_d  = '0;
                    beat_d  = '0;
                    tmo_d   = '0;
                    err_d   = req_err;
                    state_d = req_err ? S_DONE : S_ADDR;
                    if (fetch_win) begin
                        streak_d = '0;
                    end else if (iReq) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end

            S_ADDR: begin
                if (memAck) begin
                    state_d = S_XFER;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    // An aborted read reports zero data to its owner
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        if (owner_q) drdata_d = '0;
                        else         idata_d  = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_XFER: begin
                if (memStb) begin
                    tmo_d = '0;
                    if (!we_q) begin
                        rbuf_d = rbuf_ins;
                    end
                    if (beat_q == last_beat) begin
                        // Result registers load on the edge into DONE so they
                        // are already valid while the done pulse is high
                        state_d = S_DONE;
                        if (!we_q) begin
                            if (owner_q) drdata_d = rbuf_ins;
                            else         idata_d  = rbuf_ins;
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else if (memAck) begin
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        if (owner_q) drdata_d = '0;
                        else         idata_d  = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            type_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            beat_q   <= '0;
            streak_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            idata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            beat_q   <= beat_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        busy      = (state_q != S_IDLE);
        memReq    = (state_q == S_ADDR);
        memWe     = we_q;
        memType   = type_q;
        memAddr   = addr_q;
        memNibOut = ((state_q == S_XFER) && we_q) ? wdata_q[{beat_q, 2'b00} +: 4] : '0;
        iDone     = (state_q == S_DONE) && !owner_q;
        dDone     = (state_q == S_DONE) && owner_q;
        err       = (state_q == S_DONE) && err_q;
        iData     = idata_q;
        dRdata    = drdata_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a scoreboard queue of expected
// completions, a behavioural nibble-bus memory, and a done-pulse monitor.
module tb_mem_bus_arbiter;

    localparam int unsigned STARVE = 4;
    localparam int unsigned TMO    = 1024;

    logic        clk, rstN;
    logic        iReq, iDone, dReq, dWe, dDone, err, busy;
    logic [23:0] iAddr, dAddr, memAddr;
    logic [31:0] iData, dWdata, dRdata;
    logic [1:0]  dType, memType;
    logic        memReq, memAck, memWe, memStb;
    logic [3:0]  memNibOut, memNibIn;

    mem_bus_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rstN(rstN),
        .iReq(iReq), .iAddr(iAddr), .iDone(iDone), .iData(iData),
        .dReq(dReq), .dWe(dWe), .dType(dType), .dAddr(dAddr), .dWdata(dWdata),
        .dDone(dDone), .dRdata(dRdata), .err(err), .busy(busy),
        .memReq(memReq), .memAck(memAck), .memWe(memWe), .memType(memType),
        .memAddr(memAddr), .memNibOut(memNibOut), .memNibIn(memNibIn), .memStb(memStb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic [23:0] addr;
    } txn_t;

    exp_t       sbq[$];
    txn_t       txq[$];
    logic [3:0] wr_log[$];
    logic [3:0] rd_nib [8];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ack_delay = 0;
    bit         no_strobe = 0;
    int         mstate = 0, mcnt = 0, mbeat = 0, mlen = 8;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_done(input logic d, input logic e, input logic c, input logic [31:0] v);
        sbq.push_back('{d, e, c, v});
    endtask

    // Returns at the falling edge of the cycle carrying a done pulse
    task automatic wait_done(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (iDone || dDone) break;
        end
        if (i == limit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no done within %0d cycles", name, limit);
        end
    endtask

    task automatic run_data(input logic we, input logic [1:0] typ, input logic [23:0] a,
                            input logic [31:0] wd, input string name);
        @(negedge clk);
        dReq = 1'b1; dWe = we; dType = typ; dAddr = a; dWdata = wd;
        wait_done(name, 2000);
        dReq = 1'b0; dWe = 1'b0; dType = 2'b00; dAddr = '0; dWdata = '0;
    endtask

    // Memory model: acks after ack_delay cycles, then strobes one nibble per cycle
    initial begin
        memAck = 1'b0; memStb = 1'b0; memNibIn = '0;
        forever begin
            @(negedge clk);
            memAck = 1'b0; memStb = 1'b0; memNibIn = '0;
            if (!busy) mstate = 0;
            case (mstate)
                0: if (memReq) begin
                    txq.push_back('{memWe, memType, memAddr});
                    mlen  = (memType == 2'b01) ? 2 : (memType == 2'b10) ? 4 : 8;
                    mbeat = 0;
                    if (ack_delay == 0) begin
                        memAck = 1'b1; mstate = 2;
                    end else begin
                        mcnt = ack_delay; mstate = 1;
                    end
                end
                1: begin
                    mcnt--;
                    if (mcnt == 0) begin
                        memAck = 1'b1; mstate = 2;
                    end
                end
                2: if (!no_strobe) begin
                    memStb   = 1'b1;
                    memNibIn = rd_nib[mbeat];
                    if (memWe) wr_log.push_back(memNibOut);
                    mbeat++;
                    if (mbeat == mlen) mstate = 3;
                end
                default: ;
            endcase
        end
    end

    // Monitor: every done pulse pops and checks one scoreboard entry
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstN && (iDone || dDone)) begin
                if (iDone && dDone) begin
                    n_cmp++; n_bad++;
                    $display("FAIL both_done: got iDone=1 dDone=1 expected one");
                end else if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got iDone=%0b dDone=%0b expected none", iDone, dDone);
                end else begin
                    e = sbq.pop_front();
                    check("done_port", dDone, e.is_data);
                    check("done_err", err, e.err);
                    if (e.chk_data) check("done_data", e.is_data ? dRdata : iData, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int cnt, i;
        logic [3:0] nb;
        rstN = 1'b0;
        iReq = 1'b0; iAddr = '0;
        dReq = 1'b0; dWe = 1'b0; dType = 2'b00; dAddr = '0; dWdata = '0;
        rd_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, memReq, iDone, dDone, err, memWe, memType, memAddr, memNibOut, iData, dRdata}, '0);
        @(negedge clk);
        rstN = 1'b1;

        // Fetch alone, ack after 2 cycles, nibbles 1..8
        ack_delay = 2;
        expect_done(1'b0, 1'b0, 1'b1, 32'h8765_4321);
        @(negedge clk);
        iReq = 1'b1; iAddr = 24'h000100;
        @(negedge clk);
        check("grant_to_memreq", memReq, 1'b1);
        wait_done("fetch", 200);
        iReq = 1'b0; iAddr = '0;
        check("fetch_txn", (txq.size() > 0) ? {txq[$].we, txq[$].typ, txq[$].addr} : 27'h7ffffff,
              {1'b0, 2'b11, 24'h000100});
        @(negedge clk);
        check("done_one_cycle", {iDone, busy}, 2'b00);

        // Byte store: two beats, low nibble first
        ack_delay = 0;
        wr_log.delete();
        expect_done(1'b1, 1'b0, 1'b0, '0);
        run_data(1'b1, 2'b01, 24'h800003, 32'hFFFF_FFA5, "byte_store");
        check("store_beats", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            nb = wr_log[0]; check("store_nib0", nb, 4'h5);
            nb = wr_log[1]; check("store_nib1", nb, 4'hA);
        end
        check("store_txn", (txq.size() > 0) ? {txq[$].we, txq[$].typ, txq[$].addr} : 27'h0,
              {1'b1, 2'b01, 24'h800003});

        // Misaligned half load: no bus activity, done+err next cycle
        cnt = txq.size();
        expect_done(1'b1, 1'b1, 1'b0, '0);
        @(negedge clk);
        dReq = 1'b1; dWe = 1'b0; dType = 2'b10; dAddr = 24'h800001;
        @(negedge clk);
        check("err_latency", {dDone, err, memReq}, 3'b110);
        dReq = 1'b0; dType = 2'b00; dAddr = '0;
        check("err_no_memreq", txq.size(), cnt);

        // Aligned loads of each size
        rd_nib = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
        expect_done(1'b1, 1'b0, 1'b1, 32'h0FED_CBA9);
        run_data(1'b0, 2'b11, 24'h800004, '0, "word_load");
        rd_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        expect_done(1'b1, 1'b0, 1'b1, 32'h0000_0021);
        run_data(1'b0, 2'b01, 24'h800005, '0, "byte_load");
        expect_done(1'b1, 1'b0, 1'b1, 32'h0000_4321);
        run_data(1'b0, 2'b10, 24'h800006, '0, "half_load");

        // Type 00 is an error and leaves the previous load data in place
        expect_done(1'b1, 1'b1, 1'b1, 32'h0000_4321);
        run_data(1'b0, 2'b00, 24'h800008, '0, "bad_type");

        // Timeout: memory acks but never strobes
        no_strobe = 1'b1;
        expect_done(1'b1, 1'b1, 1'b1, 32'h0000_0000);
        @(negedge clk);
        dReq = 1'b1; dWe = 1'b0; dType = 2'b11; dAddr = 24'h800010;
        cnt = 0;
        for (i = 1; i <= 1200; i++) begin
            @(negedge clk);
            if (dDone) begin
                cnt = i;
                break;
            end
        end
        dReq = 1'b0; dType = 2'b00; dAddr = '0;
        check("timeout_cycles", cnt, TMO + 2);
        @(negedge clk);
        check("timeout_idle", busy, 1'b0);
        no_strobe = 1'b0;

        // Starvation: both held, order D D D D I D
        for (i = 0; i < 4; i++) expect_done(1'b1, 1'b0, 1'b1, 32'h8765_4321);
        expect_done(1'b0, 1'b0, 1'b1, 32'h8765_4321);
        expect_done(1'b1, 1'b0, 1'b1, 32'h8765_4321);
        @(negedge clk);
        iReq = 1'b1; iAddr = 24'h000400;
        dReq = 1'b1; dWe = 1'b0; dType = 2'b11; dAddr = 24'h800020;
        cnt = 0;
        for (i = 0; i < 500 && cnt < 6; i++) begin
            @(negedge clk);
            if (iDone || dDone) cnt++;
        end
        iReq = 1'b0; dReq = 1'b0; iAddr = '0; dType = 2'b00; dAddr = '0;
        check("starve_completions", cnt, 6);

        // Reset during beat 3 of a word load
        @(negedge clk);
        dReq = 1'b1; dWe = 1'b0; dType = 2'b11; dAddr = 24'h800030;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mstate == 2 && mbeat == 4) break;
        end
        check("reached_beat3", mbeat, 4);
        rstN = 1'b0;
        dReq = 1'b0; dType = 2'b00; dAddr = '0;
        #1;
        check("midreset_outputs",
              {busy, memReq, iDone, dDone, err, memWe, memType, memAddr, memNibOut, iData, dRdata}, '0);
        @(negedge clk);
        rstN = 1'b1;
        rd_nib = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};
        expect_done(1'b0, 1'b0, 1'b1, 32'h6295_1413);
        @(negedge clk);
        iReq = 1'b1; iAddr = 24'h000200;
        wait_done("fetch_after_reset", 200);
        iReq = 1'b0; iAddr = '0;

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
